// File: rtl/param_fifo_pkg.sv
// Shared defaults and sizing helpers for the parameterised synchronous FIFO.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 256;

  // Pointer width needed to address DEPTH entries; a depth of 1 still gets one bit.
  function automatic int ptr_w(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/param_fifo_ptr_ctr.sv
// Wrapping address pointer: counts 0..DEPTH-1 on en, then returns to 0.
module ptr_ctr
  import fifo_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  output logic [ptr_w(DEPTH)-1:0]  ptr
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + AW'(1);
    end
  end

endmodule

// File: rtl/param_fifo.sv
// Single-clock FIFO with registered read data, occupancy flags and error pulses.
module param_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wen,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      ren,
  output logic [DATA_W-1:0]         rdata,
  output logic                      rvalid,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic [ptr_w(DEPTH):0]     count,
  output logic                      overflow,
  output logic                      underflow
);

  localparam int AW = ptr_w(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  if (DATA_W < 1) begin : g_bad_width
    $error("param_fifo: DATA_W must be at least 1");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("param_fifo: DEPTH must be at least 2");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("param_fifo: AE_LEVEL out of range");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("param_fifo: AF_LEVEL out of range");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic              rd_acc;
  logic              wr_acc;

  // Flags come straight from the count register so they settle one cycle after an access.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO may still take a write when a read frees a slot in the same cycle.
  assign rd_acc = ren & ~empty;
  assign wr_acc = wen & (~full | rd_acc);

  ptr_ctr #(.DEPTH(DEPTH)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_acc),
    .ptr   (wptr)
  );

  ptr_ctr #(.DEPTH(DEPTH)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_acc),
    .ptr   (rptr)
  );

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wptr] <= wdata;
    end
  end

  // The read samples mem before this edge's write lands, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_acc;
      if (rd_acc) begin
        rdata <= mem[rptr];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      unique case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= wen & ~wr_acc;
      underflow <= ren & empty;
    end
  end

endmodule

// File: tb/tb_param_fifo.sv
// Directed bench for param_fifo at DEPTH=4, DATA_W=8, AF_LEVEL=3, AE_LEVEL=1.
module tb_param_fifo;

  logic       clk;
  logic       rst_n;
  logic       wen;
  logic [7:0] wdata;
  logic       ren;
  logic [7:0] rdata;
  logic       rvalid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [2:0] count;
  logic       overflow;
  logic       underflow;

  int checks   = 0;
  int failures = 0;

  param_fifo #(
    .DATA_W   (8),
    .DEPTH    (4),
    .AF_LEVEL (3),
    .AE_LEVEL (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wen          (wen),
    .wdata        (wdata),
    .ren          (ren),
    .rdata        (rdata),
    .rvalid       (rvalid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .count        (count),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic w, input logic [7:0] wd, input logic r);
    wen   = w;
    wdata = wd;
    ren   = r;
    @(posedge clk);
    #1;
    wen = 1'b0;
    ren = 1'b0;
  endtask

  task automatic flags(input string tag, input int n);
    chk({tag, ".count"}, 32'(count), 32'(n));
    chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ".full"},  32'(full),  32'(n == 4));
    chk({tag, ".ae"},    32'(almost_empty), 32'(n <= 1));
    chk({tag, ".af"},    32'(almost_full),  32'(n >= 3));
  endtask

  task automatic rd_exp(input string tag, input logic [7:0] exp, input int n);
    cyc(1'b0, 8'h00, 1'b1);
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".rdata"},  32'(rdata),  32'(exp));
    chk({tag, ".count"},  32'(count),  32'(n));
  endtask

  logic [7:0] vec_a [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
  logic [7:0] vec_b [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
  logic [7:0] vec_c [4] = '{8'h01, 8'h02, 8'h03, 8'h04};

  initial begin
    rst_n = 1'b0;
    wen   = 1'b0;
    ren   = 1'b0;
    wdata = 8'h00;
    #12;
    flags("rst", 0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.rdata",  32'(rdata),  32'd0);
    chk("rst.ovf",    32'(overflow),  32'd0);
    chk("rst.unf",    32'(underflow), 32'd0);
    #1 rst_n = 1'b1;

    // Basic order plus flag sweep across counts 0..4
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, vec_a[i], 1'b0);
      flags($sformatf("fill_a%0d", i), i + 1);
    end
    for (int i = 0; i < 4; i++) begin
      rd_exp($sformatf("drain_a%0d", i), vec_a[i], 3 - i);
      flags($sformatf("drain_a%0d", i), 3 - i);
    end
    cyc(1'b0, 8'h00, 1'b0);
    chk("idle.rvalid", 32'(rvalid), 32'd0);
    chk("idle.rdata_hold", 32'(rdata), 32'h44);

    // Overflow on a full FIFO
    for (int i = 0; i < 4; i++) cyc(1'b1, vec_b[i], 1'b0);
    cyc(1'b1, 8'hEE, 1'b0);
    chk("ovf.pulse", 32'(overflow), 32'd1);
    chk("ovf.count", 32'(count), 32'd4);
    cyc(1'b0, 8'h00, 1'b0);
    chk("ovf.clear", 32'(overflow), 32'd0);
    for (int i = 0; i < 4; i++) rd_exp($sformatf("ovf_rd%0d", i), vec_b[i], 3 - i);

    // Underflow on empty, then simultaneous write/read on empty
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf.pulse",  32'(underflow), 32'd1);
    chk("unf.rvalid", 32'(rvalid), 32'd0);
    chk("unf.count",  32'(count), 32'd0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("unf.clear",  32'(underflow), 32'd0);
    cyc(1'b1, 8'hA5, 1'b1);
    chk("wr_rd_empty.count",  32'(count), 32'd1);
    chk("wr_rd_empty.unf",    32'(underflow), 32'd1);
    chk("wr_rd_empty.rvalid", 32'(rvalid), 32'd0);
    rd_exp("wr_rd_empty.rd", 8'hA5, 0);

    // Full FIFO with simultaneous write/read for 6 cycles
    for (int i = 0; i < 4; i++) cyc(1'b1, vec_c[i], 1'b0);
    for (int i = 0; i < 6; i++) begin
      cyc(1'b1, 8'h55, 1'b1);
      chk($sformatf("thru%0d.rdata", i), 32'(rdata), (i < 4) ? 32'(vec_c[i]) : 32'h55);
      chk($sformatf("thru%0d.rvalid", i), 32'(rvalid), 32'd1);
      chk($sformatf("thru%0d.count", i), 32'(count), 32'd4);
      chk($sformatf("thru%0d.ovf", i), 32'(overflow), 32'd0);
    end
    for (int i = 0; i < 4; i++) rd_exp($sformatf("thru_rd%0d", i), 8'h55, 3 - i);

    // Asynchronous reset mid-stream with count=3 and rvalid high
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'h71 + 8'(i), 1'b0);
    rd_exp("pre_rst", 8'h71, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst.count",  32'(count), 32'd0);
    chk("async_rst.empty",  32'(empty), 32'd1);
    chk("async_rst.rvalid", 32'(rvalid), 32'd0);
    #2 rst_n = 1'b1;
    cyc(1'b1, 8'h99, 1'b0);
    chk("post_rst.count", 32'(count), 32'd1);
    rd_exp("post_rst.rd", 8'h99, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
